stage_memory: RTL and testbench

Memory stage of the pipelined core: consumes the EX/MEM pipeline register produced by `stage_execute` and performs scalar (32-bit) or vector (128-bit, 4×32-bit beats) loads and stores over a single-word request/ready data-memory bus. While an access is in flight it raises `mem_stall` so the upstream stages hold. It owns the MEM/WB pipeline register, inserting bubbles during stalls.

---
 rtl/stage_memory.sv | 151 +++++++++++++++
 tb/tb_stage_memory.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// Memory stage: scalar or 4-beat vector loads/stores over a single-word
// request/ready bus, with upstream stall generation and the MEM/WB register.
module stage_memory #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mem_instr,
    input  logic             mem_reg_write,
    input  logic             mem_mem_write,
    input  logic             mem_mem_read,
    input  logic [1:0]       mem_result_src,
    input  logic             mem_vector_op,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] mem_write_data,
    input  logic [31:0]      mem_pc_plus_4,
    input  logic [WIDTH-1:0] mem_imm_ext,
    input  logic [4:0]       mem_rd,
    output logic             mem_stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_ready,
    output logic [31:0]      wb_instr,
    output logic             wb_reg_write,
    output logic [1:0]       wb_result_src,
    output logic [WIDTH-1:0] wb_read_data,
    output logic [WIDTH-1:0] wb_alu_result,
    output logic [31:0]      wb_pc_plus_4,
    output logic [WIDTH-1:0] wb_imm_ext,
    output logic [4:0]       wb_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       beat;
    logic [WIDTH-1:0] read_buf;
    logic             we_q;
    logic             vec_q;
    logic [31:0]      base_addr;
    logic             mem_access;
    logic             last_beat;
    logic [6:0]       lane_lsb;

    assign mem_access = mem_mem_read | mem_mem_write;
    assign lane_lsb   = {beat, 5'b00000};
    assign last_beat  = (beat == (vec_q ? 2'd3 : 2'd0));

    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        case (state)
            IDLE: begin
                if (mem_access) begin
                    mem_stall  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_stall  = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = base_addr + {28'd0, beat, 2'b00};
                dmem_wdata = mem_write_data[lane_lsb +: 32];
                if (dmem_ready && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the read buffer is cleared on reset because it feeds WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= 2'd0;
            read_buf  <= '0;
            we_q      <= 1'b0;
            vec_q     <= 1'b0;
            base_addr <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_access) begin
                        base_addr <= {mem_alu_result[31:2], 2'b00};
                        we_q      <= mem_mem_write;
                        vec_q     <= mem_vector_op;
                        beat      <= 2'd0;
                        read_buf  <= '0;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        if (!we_q) begin
                            read_buf[lane_lsb +: 32] <= dmem_rdata;
                        end
                        if (!last_beat) begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A stalled cycle loads a bubble: the control fields drop, data fields hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_instr      <= 32'd0;
            wb_reg_write  <= 1'b0;
            wb_result_src <= 2'd0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_pc_plus_4  <= 32'd0;
            wb_imm_ext    <= '0;
            wb_rd         <= 5'd0;
        end else if (mem_stall) begin
            wb_instr     <= 32'd0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_instr      <= mem_instr;
            wb_reg_write  <= mem_reg_write;
            wb_result_src <= mem_result_src;
            wb_read_data  <= read_buf;
            wb_alu_result <= mem_alu_result;
            wb_pc_plus_4  <= mem_pc_plus_4;
            wb_imm_ext    <= mem_imm_ext;
            wb_rd         <= mem_rd;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized scoreboard bench for stage_memory: a word-addressed memory model
// predicts bus beats and writeback results; monitors compare independently.
module tb_stage_memory;

    localparam int WIDTH = 128;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      mem_instr;
    logic             mem_reg_write;
    logic             mem_mem_write;
    logic             mem_mem_read;
    logic [1:0]       mem_result_src;
    logic             mem_vector_op;
    logic [WIDTH-1:0] mem_alu_result;
    logic [WIDTH-1:0] mem_write_data;
    logic [31:0]      mem_pc_plus_4;
    logic [WIDTH-1:0] mem_imm_ext;
    logic [4:0]       mem_rd;
    logic             mem_stall;
    logic             dmem_req;
    logic             dmem_we;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;
    logic             dmem_ready;
    logic [31:0]      wb_instr;
    logic             wb_reg_write;
    logic [1:0]       wb_result_src;
    logic [WIDTH-1:0] wb_read_data;
    logic [WIDTH-1:0] wb_alu_result;
    logic [31:0]      wb_pc_plus_4;
    logic [WIDTH-1:0] wb_imm_ext;
    logic [4:0]       wb_rd;

    stage_memory #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .mem_instr(mem_instr), .mem_reg_write(mem_reg_write),
        .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
        .mem_result_src(mem_result_src), .mem_vector_op(mem_vector_op),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_pc_plus_4(mem_pc_plus_4), .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .wb_instr(wb_instr), .wb_reg_write(wb_reg_write),
        .wb_result_src(wb_result_src), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_pc_plus_4(wb_pc_plus_4),
        .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      instr;
        logic             reg_write;
        logic [1:0]       result_src;
        logic [WIDTH-1:0] read_data;
        logic [WIDTH-1:0] alu_result;
        logic [31:0]      pc_plus_4;
        logic [WIDTH-1:0] imm_ext;
        logic [4:0]       rd;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0]      instr;
        logic             reg_write;
        logic             rd_en;
        logic             wr_en;
        logic             vec;
        logic [1:0]       src;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] imm;
        logic [31:0]      pc;
        logic [4:0]       rd;
    } op_t;

    wb_t         wb_q[$];
    beat_t       bus_q[$];
    logic [31:0] model_mem[bit [29:0]];
    logic [31:0] bus_mem[bit [29:0]];
    logic [WIDTH-1:0] model_buf;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus responder controls: 0 = always ready, 1 = random ready.
    int ready_mode = 0;
    int hold_beat  = -1;
    int beats_done = 0;
    bit held       = 1'b0;
    int wait_cycles = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] default_word(input bit [29:0] w);
        return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a[31:2])) return model_mem[a[31:2]];
        return default_word(a[31:2]);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a[31:2])) return bus_mem[a[31:2]];
        return default_word(a[31:2]);
    endfunction

    // Bus responder and beat checker.
    always @(negedge clk) begin
        if (dmem_req) begin
            dmem_rdata = bus_rd(dmem_addr);
            if (hold_beat == beats_done && !held) begin
                dmem_ready = 1'b0;
                held = 1'b1;
            end else begin
                dmem_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            end
            if (!dmem_ready) wait_cycles++;
            if (bus_q.size() == 0) begin
                check("bus_unexpected_req", {31'd0, dmem_req}, '0);
            end else begin
                check("bus_addr", dmem_addr, bus_q[0].addr);
                check("bus_we", dmem_we, bus_q[0].we);
                check("bus_wdata", dmem_wdata, bus_q[0].wdata);
                if (dmem_ready) begin
                    if (dmem_we) bus_mem[dmem_addr[31:2]] = dmem_wdata;
                    void'(bus_q.pop_front());
                    beats_done++;
                end
            end
        end else begin
            dmem_rdata = $urandom;
            dmem_ready = $urandom_range(1);
            check("idle_bus_outputs", {dmem_we, dmem_addr, dmem_wdata}, '0);
        end
    end

    // Writeback monitor: nonzero wb_instr marks a retired instruction,
    // otherwise the register must hold a bubble with data fields unchanged.
    wb_t prev_wb;
    bit  prev_reset = 1'b1;
    always @(negedge clk) begin
        wb_t exp;
        if (wb_instr !== 32'd0) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected_retire", wb_instr, '0);
            end else begin
                exp = wb_q.pop_front();
                check("wb_instr", wb_instr, exp.instr);
                check("wb_reg_write", wb_reg_write, exp.reg_write);
                check("wb_result_src", wb_result_src, exp.result_src);
                check("wb_read_data", wb_read_data, exp.read_data);
                check("wb_alu_result", wb_alu_result, exp.alu_result);
                check("wb_pc_plus_4", wb_pc_plus_4, exp.pc_plus_4);
                check("wb_imm_ext", wb_imm_ext, exp.imm_ext);
                check("wb_rd", wb_rd, exp.rd);
            end
        end else if (!reset && !prev_reset) begin
            check("bubble_reg_write", wb_reg_write, '0);
            check("bubble_hold_rd", wb_rd, prev_wb.rd);
            check("bubble_hold_alu", wb_alu_result, prev_wb.alu_result);
            check("bubble_hold_read_data", wb_read_data, prev_wb.read_data);
            check("bubble_hold_pc", wb_pc_plus_4, prev_wb.pc_plus_4);
            check("bubble_hold_imm", wb_imm_ext, prev_wb.imm_ext);
            check("bubble_hold_src", wb_result_src, prev_wb.result_src);
        end
        prev_wb.rd         = wb_rd;
        prev_wb.alu_result = wb_alu_result;
        prev_wb.read_data  = wb_read_data;
        prev_wb.pc_plus_4  = wb_pc_plus_4;
        prev_wb.imm_ext    = wb_imm_ext;
        prev_wb.result_src = wb_result_src;
        prev_reset         = reset;
    end

    task automatic zero_inputs();
        mem_instr = '0; mem_reg_write = 0; mem_mem_write = 0; mem_mem_read = 0;
        mem_result_src = '0; mem_vector_op = 0; mem_alu_result = '0;
        mem_write_data = '0; mem_pc_plus_4 = '0; mem_imm_ext = '0; mem_rd = '0;
    endtask

    // Idle keeps data fields so an idle retirement looks like a bubble.
    task automatic go_idle();
        @(posedge clk); #1;
        mem_instr = '0; mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0;
    endtask

    // Drives one instruction and pushes every expectation it implies;
    // returns the expected stall count excluding bus wait cycles.
    task automatic drive_op(input op_t op, input int mode, input int hb, output int exp_stall);
        wb_t         exp;
        logic [31:0] base;
        logic [31:0] a;
        int          n;
        @(posedge clk); #1;
        mem_instr = op.instr; mem_reg_write = op.reg_write;
        mem_mem_read = op.rd_en; mem_mem_write = op.wr_en;
        mem_result_src = op.src; mem_vector_op = op.vec;
        mem_alu_result = op.alu; mem_write_data = op.wdata;
        mem_pc_plus_4 = op.pc; mem_imm_ext = op.imm; mem_rd = op.rd;
        ready_mode = mode; hold_beat = hb; held = 1'b0;
        beats_done = 0; wait_cycles = 0;
        exp_stall = 0;
        if (op.rd_en || op.wr_en) begin
            n = op.vec ? 4 : 1;
            base = {op.alu[31:2], 2'b00};
            model_buf = '0;
            for (int i = 0; i < n; i++) begin
                a = base + 32'(4 * i);
                bus_q.push_back('{addr: a, we: op.wr_en, wdata: op.wdata[32*i +: 32]});
                if (op.wr_en) model_mem[a[31:2]] = op.wdata[32*i +: 32];
                else          model_buf[32*i +: 32] = model_rd(a);
            end
            exp_stall = 1 + n;
        end
        exp.instr = op.instr; exp.reg_write = op.reg_write; exp.result_src = op.src;
        exp.read_data = model_buf; exp.alu_result = op.alu; exp.pc_plus_4 = op.pc;
        exp.imm_ext = op.imm; exp.rd = op.rd;
        wb_q.push_back(exp);
    endtask

    task automatic run_op(input op_t op, input int mode, input int hb);
        int exp_stall;
        int stalls;
        drive_op(op, mode, hb, exp_stall);
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            if (stalls > 60) begin
                check("stall_budget_expired", 128'(stalls), 128'd60);
                break;
            end
        end
        check("stall_cycles", 128'(stalls), 128'(exp_stall + wait_cycles));
    endtask

    function automatic op_t make_op(input logic [31:0] instr, input logic rw, input logic rd_en,
                                    input logic wr_en, input logic vec, input logic [WIDTH-1:0] alu,
                                    input logic [WIDTH-1:0] wdata, input logic [4:0] rd);
        op_t o;
        o.instr = instr; o.reg_write = rw; o.rd_en = rd_en; o.wr_en = wr_en; o.vec = vec;
        o.src = instr[1:0]; o.alu = alu; o.wdata = wdata; o.imm = {4{instr ^ 32'h0F0F0F0F}};
        o.pc = instr + 32'd4; o.rd = rd;
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t op;
        int  exp_stall;
        int  budget;
        int  kind;
        logic [31:0] a;

        reset = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        model_buf = '0;
        zero_inputs();
        repeat (3) @(negedge clk);
        check("reset_wb_instr", wb_instr, '0);
        check("reset_wb_reg_write", wb_reg_write, '0);
        check("reset_wb_read_data", wb_read_data, '0);
        check("reset_wb_alu_result", wb_alu_result, '0);
        check("reset_wb_rd", wb_rd, '0);
        check("reset_mem_stall", mem_stall, '0);
        check("reset_dmem_req", dmem_req, '0);
        #1 reset = 1'b0;

        // Non-memory op: no stall, visible in WB the next edge.
        run_op(make_op(32'h0000_0013, 1, 0, 0, 0, 128'h1234, '0, 5'd5), 0, -1);

        // Scalar load, misaligned address, known word in memory.
        model_mem[30'h40] = 32'hDEADBEEF;
        bus_mem[30'h40]   = 32'hDEADBEEF;
        run_op(make_op(32'h0000_1003, 1, 1, 0, 0, 128'h103, '0, 5'd7), 0, -1);

        // Vector store with one ready-low cycle on beat 2.
        run_op(make_op(32'h0000_2023, 0, 0, 1, 1, 128'h200,
                       {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 5'd0), 0, 2);

        // Vector load reading the store back, then one wrapping past 2^32.
        run_op(make_op(32'h0000_3007, 1, 1, 0, 1, 128'h200, '0, 5'd9), 0, -1);
        bus_mem[30'h0] = 32'hA0A0A0A0; model_mem[30'h0] = 32'hA0A0A0A0;
        run_op(make_op(32'h0000_4007, 1, 1, 0, 1, 128'hFFFFFFF8, '0, 5'd10), 0, -1);

        // Read and write together behaves as a scalar store.
        run_op(make_op(32'h0000_5023, 1, 1, 1, 0, 128'h300, 128'hCAFEF00D, 5'd11), 0, -1);
        run_op(make_op(32'h0000_6003, 1, 1, 0, 0, 128'h301, '0, 5'd12), 0, -1);

        // Randomized back-to-back mix with random bus waits.
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(4);
            a = (k % 7 == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(15))
                             : 32'h1000 + 32'($urandom_range(127));
            op = make_op($urandom | 32'h1, 1'($urandom), kind == 1 || kind == 2,
                         kind == 3 || kind == 2, 1'($urandom),
                         {$urandom, $urandom, $urandom, a},
                         {$urandom, $urandom, $urandom, $urandom}, 5'($urandom));
            run_op(op, 1, -1);
        end
        go_idle();
        repeat (3) @(negedge clk);

        // Reset during beat 1 of a vector load.
        drive_op(make_op(32'h0000_7007, 1, 1, 0, 1, 128'h1100, '0, 5'd13), 0, -1, exp_stall);
        budget = 0;
        while (!(dmem_req && dmem_addr == 32'h1104) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("reach_beat1", dmem_addr, 128'h1104);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_busy_dmem_req", dmem_req, '0);
        check("rst_busy_dmem_addr", dmem_addr, '0);
        check("rst_busy_wb_instr", wb_instr, '0);
        check("rst_busy_wb_rd", wb_rd, '0);
        check("rst_busy_wb_read_data", wb_read_data, '0);
        check("rst_busy_wb_alu", wb_alu_result, '0);
        #1;
        reset = 1'b0;
        zero_inputs();
        wb_q.delete();
        bus_q.delete();
        model_buf = '0;

        run_op(make_op(32'h0000_8013, 1, 0, 0, 0, 128'h55, '0, 5'd14), 0, -1);
        run_op(make_op(32'h0000_9003, 1, 1, 0, 0, 128'h1104, '0, 5'd15), 1, -1);
        go_idle();
        repeat (4) @(negedge clk);
        check("wb_queue_drained", 128'(wb_q.size()), '0);
        check("bus_queue_drained", 128'(bus_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
